alu_mul_sequencer: RTL and testbench
====================================

// Module: alu_mul_sequencer
// PURPOSE
//  Multi-cycle controller that borrows the EX-stage 64-bit ALU to run unsigned MUL by shift-and-add.
//  - Idle: EX-stage ALU requests pass straight through to the ALU.
//  - MUL in progress: the sequencer drives the ALU with ADD and SLLI, and raises `stall` to freeze the pipeline.
//  - Sits between EX-stage decode and the ALU. Returns the low XLEN bits of the product.
// PARAMETERS
//  XLEN   64  operand/result width; ALU width
//  CNT_W  6   iteration counter width; must equal clog2(XLEN)
// PORTS
//  clk         in   1     single clock, rising edge
//  reset       in   1     synchronous, active-high
//  ex_alu_op   in   4     EX-stage ALUOp (pass-through)
//  ex_a        in   XLEN  EX-stage operand a (pass-through)
//  ex_b        in   XLEN  EX-stage operand b (pass-through)
//  mul_start   in   1     request MUL of mul_a*mul_b; sampled only in IDLE
//  mul_a       in   XLEN  multiplicand
//  mul_b       in   XLEN  multiplier
//  alu_result  in   XLEN  ALU Result output
//  alu_op      out  4     ALUOp driven to ALU
//  alu_a       out  XLEN  ALU operand a
//  alu_b       out  XLEN  ALU operand b
//  stall       out  1     1 while the sequencer owns the ALU (ADD/SHIFT/DONE)
//  mul_done    out  1     one-cycle pulse; mul_result valid this cycle
//  mul_result  out  XLEN  product, low XLEN bits; holds until next mul_done
// BEHAVIOUR
//  Reset values: state=IDLE, acc=0, mcand=0, mplr=0, cnt=0, mul_done=0, mul_result=0, stall=0.
//  ALU encodings: ADD=4'b0010, SLLI=4'b1111.
//  ALU mux (combinational):
//   - IDLE: alu_* = ex_*.
//   - ADD: alu_op=ADD, alu_a=acc, alu_b=mcand.
//   - SHIFT: alu_op=SLLI, alu_a=mcand, alu_b=1.
//   - DONE: alu_* = ex_* (pipeline still stalled).
//  FSM:
//   - IDLE + mul_start: acc<=0, mcand<=mul_a, mplr<=mul_b, cnt<=0.
//     Next state is ADD if mul_b[0]=1, otherwise SHIFT.
//   - ADD: acc<=alu_result; next state SHIFT.
//   - SHIFT: mcand<=alu_result; mplr<=mplr>>1 (local shifter, not the ALU); cnt<=cnt+1.
//     If cnt==XLEN-1, next state DONE; else ADD if mplr[1]=1, otherwise SHIFT.
//   - DONE: mul_result<=acc at entry; mul_done=1 for this cycle; next state IDLE.
//  Latency: mul_done asserts popcount(mul_b)+XLEN+1 cycles after the mul_start edge.
//  Arithmetic: all sums wrap mod 2^XLEN (ALU ADD wraps); operands are unsigned.
//  Boundaries:
//   - mul_start while state!=IDLE is ignored; the request is not queued.
//   - mul_start in the DONE cycle is also ignored; it is accepted on the following IDLE cycle.
//   - mul_b=0: no ADD cycles.
//   - mul_b=all-ones: an ADD before every SHIFT, 2*XLEN+1 cycles.
//   - reset mid-operation: IDLE next cycle, all registers back to reset values, no mul_done pulse.
//   - stall=0 only in IDLE.
// CONFIGURATION
//  MUL_EARLY_TERM_EN defined:
//   - In SHIFT, if (mplr>>1)==0, go to DONE regardless of cnt.
//   - On accept, if mul_b==0, go directly to DONE.
//   - Latency = (number of ADDs) + (index of highest set bit + 1) + 1, or 1 when mul_b=0.
//  MUL_EARLY_TERM_EN undefined: fixed XLEN SHIFT iterations, as specified above.
// STRUCTURE
//  Package alu_pkg:
//   - ALUOP_AND/OR/ADD/SUB/NOR/BLT/ADDI/SLLI 4-bit constants.
//   - mul_state_t enum {IDLE, ADD, SHIFT, DONE}.
//  Sub-module alu_port_mux: combinational selection of the ALU op/a/b from ex_* or sequencer drive, keyed on state.
//  Bench instantiates the real 64-bit ALU downstream of alu_op/alu_a/alu_b.
// TESTING
//  1. Idle pass-through: ex_alu_op=SUB, ex_a=10, ex_b=3 -> alu_op=0110, ALU result 7, stall=0.
//  2. mul_a=3, mul_b=5:
//     - default -> mul_done at cycle 67, mul_result=15.
//     - EARLY_TERM -> mul_done at cycle 6, mul_result=15.
//  3. mul_a=2^63, mul_b=2:
//     - mul_result=0 (wrap).
//     - mul_a=all-ones, mul_b=all-ones -> mul_result=1; default latency 129.
//  4. mul_b=0 -> mul_result=0; default latency 65, EARLY_TERM latency 1; stall=1 throughout.
//  5. Second mul_start pulsed at cycle 10 of a busy op -> ignored; exactly one mul_done; result of first op.
//  6. reset asserted at cycle 20 of 3*5 -> next cycle IDLE, stall=0, mul_result=0; no mul_done pulse.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings and multiply-sequencer state type.
package alu_pkg;

    localparam logic [3:0] ALUOP_AND  = 4'b0000;
    localparam logic [3:0] ALUOP_OR   = 4'b0001;
    localparam logic [3:0] ALUOP_ADD  = 4'b0010;
    localparam logic [3:0] ALUOP_ADDI = 4'b0011;
    localparam logic [3:0] ALUOP_SUB  = 4'b0110;
    localparam logic [3:0] ALUOP_BLT  = 4'b0111;
    localparam logic [3:0] ALUOP_NOR  = 4'b1100;
    localparam logic [3:0] ALUOP_SLLI = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        SHIFT,
        DONE
    } mul_state_t;

endpackage

// File: rtl/alu_port_mux.sv
// Selects what drives the ALU: EX-stage request, or the multiply sequencer's ADD/SLLI step.
module alu_port_mux
    import alu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [1:0]      state,
    input  logic [3:0]      ex_alu_op,
    input  logic [XLEN-1:0] ex_a,
    input  logic [XLEN-1:0] ex_b,
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] mcand,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b
);

    localparam logic [XLEN-1:0] ONE = {{(XLEN-1){1'b0}}, 1'b1};

    always_comb begin
        alu_op = ex_alu_op;
        alu_a  = ex_a;
        alu_b  = ex_b;
        case (mul_state_t'(state))
            ADD: begin
                alu_op = ALUOP_ADD;
                alu_a  = acc;
                alu_b  = mcand;
            end
            SHIFT: begin
                alu_op = ALUOP_SLLI;
                alu_a  = mcand;
                alu_b  = ONE;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add unsigned multiplier that borrows the EX-stage ALU, stalling the pipeline.
// Define MUL_EARLY_TERM_EN to finish as soon as no multiplier bits remain.
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      ex_alu_op,
    input  logic [XLEN-1:0] ex_a,
    input  logic [XLEN-1:0] ex_b,
    input  logic            mul_start,
    input  logic [XLEN-1:0] mul_a,
    input  logic [XLEN-1:0] mul_b,
    input  logic [XLEN-1:0] alu_result,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic            stall,
    output logic            mul_done,
    output logic [XLEN-1:0] mul_result
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    mul_state_t       state;
    logic [XLEN-1:0]  acc;
    logic [XLEN-1:0]  mcand;
    logic [XLEN-1:0]  mplr;
    logic [CNT_W-1:0] cnt;
    logic             shift_last;

    always_comb begin
        shift_last = (cnt == CNT_LAST);
`ifdef MUL_EARLY_TERM_EN
        shift_last = shift_last || (mplr[XLEN-1:1] == '0);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            acc        <= '0;
            mcand      <= '0;
            mplr       <= '0;
            cnt        <= '0;
            mul_done   <= 1'b0;
            mul_result <= '0;
            stall      <= 1'b0;
        end else begin
            mul_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (mul_start) begin
                        acc   <= '0;
                        mcand <= mul_a;
                        mplr  <= mul_b;
                        cnt   <= '0;
                        stall <= 1'b1;
                        state <= mul_b[0] ? ADD : SHIFT;
`ifdef MUL_EARLY_TERM_EN
                        // Zero multiplier: the product is known to be zero immediately.
                        if (mul_b == '0) begin
                            state      <= DONE;
                            mul_done   <= 1'b1;
                            mul_result <= '0;
                        end
`endif
                    end
                end
                ADD: begin
                    acc   <= alu_result;
                    state <= SHIFT;
                end
                SHIFT: begin
                    mcand <= alu_result;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt + 1'b1;
                    if (shift_last) begin
                        state      <= DONE;
                        mul_done   <= 1'b1;
                        mul_result <= acc;
                    end else begin
                        // mplr[1] becomes the low multiplier bit after this shift.
                        state <= mplr[1] ? ADD : SHIFT;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    stall <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    alu_port_mux #(
        .XLEN (XLEN)
    ) u_alu_port_mux (
        .state     (state),
        .ex_alu_op (ex_alu_op),
        .ex_a      (ex_a),
        .ex_b      (ex_b),
        .acc       (acc),
        .mcand     (mcand),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b)
    );

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer with a behavioural 64-bit ALU downstream.
// Honours MUL_EARLY_TERM_EN for expected latencies.
module tb_alu_mul_sequencer;

    localparam int XLEN  = 64;
    localparam int CNT_W = 6;
    localparam logic [XLEN-1:0] BUSY_B = 64'h8000_0000_0000_0005;

    logic            clk       = 1'b0;
    logic            reset     = 1'b1;
    logic [3:0]      ex_alu_op = 4'b0000;
    logic [XLEN-1:0] ex_a      = '0;
    logic [XLEN-1:0] ex_b      = '0;
    logic            mul_start = 1'b0;
    logic [XLEN-1:0] mul_a     = '0;
    logic [XLEN-1:0] mul_b     = '0;
    logic [XLEN-1:0] alu_result;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic            stall;
    logic            mul_done;
    logic [XLEN-1:0] mul_result;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_mul_sequencer #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ex_alu_op  (ex_alu_op),
        .ex_a       (ex_a),
        .ex_b       (ex_b),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .alu_result (alu_result),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .stall      (stall),
        .mul_done   (mul_done),
        .mul_result (mul_result)
    );

    // Behavioural ALU
    always_comb begin
        case (alu_op)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            4'b1111: alu_result = alu_a << alu_b[5:0];
            default: alu_result = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic [XLEN-1:0] b);
`ifdef MUL_EARLY_TERM_EN
        int hi;
        hi = -1;
        for (int i = 0; i < XLEN; i++) if (b[i]) hi = i;
        if (hi < 0) return 1;
        return $countones(b) + hi + 2;
`else
        return $countones(b) + XLEN + 1;
`endif
    endfunction

    // Starts a multiply at the next edge; returns #1 after the edge where mul_done is seen.
    task automatic run_mul(input string tag, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        int              cycles;
        logic            stall_ok;
        logic [XLEN-1:0] prod;
        prod      = a * b;
        mul_a     = a;
        mul_b     = b;
        mul_start = 1'b1;
        @(posedge clk); #1;
        mul_start = 1'b0;
        cycles    = 1;
        stall_ok  = 1'b1;
        while (mul_done !== 1'b1 && cycles < 300) begin
            if (stall !== 1'b1) stall_ok = 1'b0;
            @(posedge clk); #1;
            cycles++;
        end
        chk({tag, " latency"}, XLEN'(cycles), XLEN'(exp_lat(b)));
        chk({tag, " result"}, mul_result, prod);
        chk({tag, " stall"}, XLEN'(stall_ok & stall), 64'd1);
        chk({tag, " done_passthru"}, XLEN'(alu_op), XLEN'(ex_alu_op));
    endtask

    initial begin
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] exp_res;
        int              pulses;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset stall", XLEN'(stall), 64'd0);
        chk("reset mul_done", XLEN'(mul_done), 64'd0);
        chk("reset mul_result", mul_result, 64'd0);

        // Idle pass-through: SUB 10-3
        ex_alu_op = 4'b0110;
        ex_a      = 64'd10;
        ex_b      = 64'd3;
        #1;
        chk("idle alu_op", XLEN'(alu_op), 64'h6);
        chk("idle alu_result", alu_result, 64'd7);
        chk("idle stall", XLEN'(stall), 64'd0);

        run_mul("mul 3x5", 64'd3, 64'd5);
        @(posedge clk); #1;
        chk("pulse drops", XLEN'(mul_done), 64'd0);
        chk("result holds", mul_result, 64'd15);
        chk("idle again", XLEN'(stall), 64'd0);

        run_mul("mul wrap", 64'h8000_0000_0000_0000, 64'd2);
        @(posedge clk); #1;
        run_mul("mul ones", '1, '1);
        @(posedge clk); #1;
        run_mul("mul b0", 64'd12345, 64'd0);
        @(posedge clk); #1;

        // mul_start raised during DONE is ignored, then accepted in IDLE
        run_mul("mul pre", 64'd7, 64'd6);
        mul_a     = 64'd11;
        mul_b     = 64'd13;
        mul_start = 1'b1;
        @(posedge clk); #1;
        chk("done start ignored", XLEN'(stall), 64'd0);
        chk("done start no pulse", XLEN'(mul_done), 64'd0);
        run_mul("mul post", 64'd11, 64'd13);
        @(posedge clk); #1;

        // Second start while busy is dropped
        a         = 64'd3;
        exp_res   = a * BUSY_B;
        mul_a     = a;
        mul_b     = BUSY_B;
        mul_start = 1'b1;
        pulses    = 0;
        for (int c = 1; c <= 220; c++) begin
            @(posedge clk); #1;
            mul_start = 1'b0;
            if (mul_done === 1'b1) begin
                pulses++;
                chk("busy result", mul_result, exp_res);
            end
            if (c == 9) begin
                mul_a     = 64'd99;
                mul_b     = 64'd77;
                mul_start = 1'b1;
            end
        end
        chk("busy pulses", XLEN'(pulses), 64'd1);

        // Reset in the middle of an operation
        mul_a     = 64'd3;
        mul_b     = BUSY_B;
        mul_start = 1'b1;
        @(posedge clk); #1;
        mul_start = 1'b0;
        repeat (18) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midreset stall", XLEN'(stall), 64'd0);
        chk("midreset mul_done", XLEN'(mul_done), 64'd0);
        chk("midreset mul_result", mul_result, 64'd0);
        chk("midreset passthru", XLEN'(alu_op), XLEN'(ex_alu_op));
        reset  = 1'b0;
        pulses = 0;
        for (int c = 0; c < 150; c++) begin
            @(posedge clk); #1;
            if (mul_done === 1'b1) pulses++;
        end
        chk("midreset no pulse", XLEN'(pulses), 64'd0);

        // Randomized operands against the plain-arithmetic model
        for (int k = 0; k < 8; k++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (k % 2 == 1) b = b >> $urandom_range(63, 40);
            run_mul("mul rand", a, b);
            exp_res = a * b;
            @(posedge clk); #1;
            chk("rand pulse drops", XLEN'(mul_done), 64'd0);
            chk("rand result holds", mul_result, exp_res);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
